dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 143 ++++++++++++++
 tb/tb_dma_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dma_ctrl
// Brief   : Single-byte RX-FIFO-to-RAM and RAM-to-serial-TX DMA engine, Moore outputs.
// Revision: 1.0 - initial release
// ============================================================================
module dma_ctrl #(
    parameter logic [7:0] RX_BASE = 8'h00,
    parameter int         RX_LEN  = 3,
    parameter logic [7:0] TX_BASE = 8'h04,
    parameter int         TX_LEN  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    output logic       DMA_Req,
    input  logic       DMA_Ack,
    input  logic       DMA_Tx_Start,
    output logic       DMA_Ready,
    input  logic [7:0] RX_Data,
    input  logic       RX_Empty,
    output logic       RX_Data_Read,
    output logic [7:0] TX_Data,
    output logic       TX_Valid,
    input  logic       TX_Ready,
    output logic [7:0] RAM_Addr,
    output logic       RAM_Cs,
    output logic       RAM_Wen,
    output logic       RAM_Oen,
    output logic [7:0] Databus_o,
    output logic       Databus_oe,
    input  logic [7:0] Databus_i
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RX_REQ   = 3'd1;
    localparam logic [2:0] S_RX_WR    = 3'd2;
    localparam logic [2:0] S_TX_RD    = 3'd3;
    localparam logic [2:0] S_TX_LATCH = 3'd4;
    localparam logic [2:0] S_TX_SEND  = 3'd5;

    localparam logic [2:0] c_RX_LAST = 3'(RX_LEN - 1);
    localparam logic [2:0] c_TX_LAST = 3'(TX_LEN - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_rx_cnt;
    logic [2:0] r_tx_cnt;
    logic [2:0] w_tx_cnt_nxt;
    logic       r_tx_pending;
    logic       w_tx_fire;
    logic       w_next_is_tx;

    assign w_tx_fire    = (r_state == S_TX_SEND) && TX_Valid && TX_Ready;
    assign w_tx_cnt_nxt = !w_tx_fire               ? r_tx_cnt :
                          (r_tx_cnt == c_TX_LAST)  ? 3'd0     : r_tx_cnt + 3'd1;
    assign w_next_is_tx = (w_next_state == S_TX_RD) || (w_next_state == S_TX_LATCH) ||
                          (w_next_state == S_TX_SEND);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // A TX start wins over a waiting RX byte in the same cycle.
                if (DMA_Tx_Start || r_tx_pending) begin
                    w_next_state = S_TX_RD;
                end else if (!RX_Empty) begin
                    w_next_state = S_RX_REQ;
                end
            end
            S_RX_REQ:   if (DMA_Ack) w_next_state = S_RX_WR;
            S_RX_WR:    w_next_state = S_IDLE;
            S_TX_RD:    w_next_state = S_TX_LATCH;
            S_TX_LATCH: w_next_state = S_TX_SEND;
            S_TX_SEND: begin
                if (w_tx_fire) begin
                    w_next_state = (r_tx_cnt == c_TX_LAST) ? S_IDLE : S_TX_RD;
                end
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they are registered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_rx_cnt     <= 3'd0;
            r_tx_cnt     <= 3'd0;
            r_tx_pending <= 1'b0;
            DMA_Req      <= 1'b0;
            DMA_Ready    <= 1'b1;
            RX_Data_Read <= 1'b0;
            TX_Data      <= 8'h00;
            TX_Valid     <= 1'b0;
            RAM_Addr     <= 8'h00;
            RAM_Cs       <= 1'b0;
            RAM_Wen      <= 1'b0;
            RAM_Oen      <= 1'b0;
            Databus_o    <= 8'h00;
            Databus_oe   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tx_cnt <= w_tx_cnt_nxt;

            if (r_state == S_RX_WR) begin
                r_rx_cnt <= (r_rx_cnt == c_RX_LAST) ? 3'd0 : r_rx_cnt + 3'd1;
            end

            if (((r_state == S_RX_REQ) || (r_state == S_RX_WR)) && DMA_Tx_Start) begin
                r_tx_pending <= 1'b1;
            end else if ((r_state == S_IDLE) && (w_next_state == S_TX_RD)) begin
                r_tx_pending <= 1'b0;
            end

            DMA_Req      <= (w_next_state == S_RX_REQ) || (w_next_state == S_RX_WR);
            DMA_Ready    <= !w_next_is_tx;
            RX_Data_Read <= (w_next_state == S_RX_WR);
            RAM_Cs       <= (w_next_state == S_RX_WR) || (w_next_state == S_TX_RD);
            RAM_Wen      <= (w_next_state == S_RX_WR);
            RAM_Oen      <= (w_next_state == S_TX_RD);
            Databus_oe   <= (w_next_state == S_RX_WR);

            if (w_next_state == S_RX_WR) begin
                RAM_Addr  <= RX_BASE + {5'd0, r_rx_cnt};
                Databus_o <= RX_Data;
            end else if (w_next_state == S_TX_RD) begin
                RAM_Addr  <= TX_BASE + {5'd0, w_tx_cnt_nxt};
            end else begin
                RAM_Addr  <= 8'h00;
            end

            // RAM read data is valid in the cycle after the read strobe.
            if (r_state == S_TX_LATCH) begin
                TX_Data  <= Databus_i;
                TX_Valid <= 1'b1;
            end else if (w_tx_fire) begin
                TX_Valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_ctrl
// Brief   : Directed self-checking bench for dma_ctrl with a behavioural RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dma_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       DMA_Req;
    logic       DMA_Ack;
    logic       DMA_Tx_Start;
    logic       DMA_Ready;
    logic [7:0] RX_Data;
    logic       RX_Empty;
    logic       RX_Data_Read;
    logic [7:0] TX_Data;
    logic       TX_Valid;
    logic       TX_Ready;
    logic [7:0] RAM_Addr;
    logic       RAM_Cs;
    logic       RAM_Wen;
    logic       RAM_Oen;
    logic [7:0] Databus_o;
    logic       Databus_oe;
    logic [7:0] Databus_i;

    int total = 0;
    int bad   = 0;
    logic init_mem = 1'b0;
    logic run_chk  = 1'b0;
    logic [7:0] mem [0:255];
    logic [7:0] rd_q;

    always #5 Clk = ~Clk;

    dma_ctrl dut (
        .Clk(Clk), .Rst(Rst), .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack),
        .DMA_Tx_Start(DMA_Tx_Start), .DMA_Ready(DMA_Ready), .RX_Data(RX_Data),
        .RX_Empty(RX_Empty), .RX_Data_Read(RX_Data_Read), .TX_Data(TX_Data),
        .TX_Valid(TX_Valid), .TX_Ready(TX_Ready), .RAM_Addr(RAM_Addr),
        .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
        .Databus_o(Databus_o), .Databus_oe(Databus_oe), .Databus_i(Databus_i)
    );

    // Synchronous RAM: read data appears one cycle after the read strobe.
    always @(posedge Clk) begin
        if (init_mem) begin
            mem[8'h04] <= 8'h3C;
            mem[8'h05] <= 8'hC3;
            rd_q       <= 8'h00;
        end else begin
            if (RAM_Cs && RAM_Wen) mem[RAM_Addr] <= Databus_o;
            if (RAM_Cs && RAM_Oen) rd_q <= mem[RAM_Addr];
        end
    end
    assign Databus_i = rd_q;

    always @(negedge Clk) begin
        if (run_chk) begin
            total++;
            assert ((RAM_Wen && RAM_Oen) === 1'b0 && (!Databus_oe || RAM_Wen) === 1'b1)
            else begin
                bad++;
                $error("FAIL bus_excl: wen=%0b oen=%0b oe=%0b", RAM_Wen, RAM_Oen, Databus_oe);
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   {7'd0, DMA_Req},      8'h00);
        chk({tag, "_rdy"},   {7'd0, DMA_Ready},    8'h01);
        chk({tag, "_cs"},    {7'd0, RAM_Cs},       8'h00);
        chk({tag, "_wen"},   {7'd0, RAM_Wen},      8'h00);
        chk({tag, "_oen"},   {7'd0, RAM_Oen},      8'h00);
        chk({tag, "_oe"},    {7'd0, Databus_oe},   8'h00);
        chk({tag, "_txv"},   {7'd0, TX_Valid},     8'h00);
        chk({tag, "_pop"},   {7'd0, RX_Data_Read}, 8'h00);
        chk({tag, "_addr"},  RAM_Addr,             8'h00);
        chk({tag, "_txd"},   TX_Data,              8'h00);
    endtask

    task automatic do_reset;
        Rst = 1'b1; init_mem = 1'b1;
        DMA_Ack = 1'b0; DMA_Tx_Start = 1'b0; RX_Empty = 1'b1;
        RX_Data = 8'h00; TX_Ready = 1'b0;
        tick; tick;
        Rst = 1'b0; init_mem = 1'b0;
        run_chk = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic [7:0] a);
        int n;
        RX_Data = d; RX_Empty = 1'b0; DMA_Ack = 1'b1;
        n = 0;
        do begin tick; n++; end while (RX_Data_Read !== 1'b1 && n < 8);
        chk("rx_pop",  {7'd0, RX_Data_Read}, 8'h01);
        chk("rx_addr", RAM_Addr, a);
        chk("rx_dbo",  Databus_o, d);
        chk("rx_wen",  {7'd0, RAM_Wen}, 8'h01);
        RX_Empty = 1'b1; DMA_Ack = 1'b0;
        tick;
        chk("rx_req_drop", {7'd0, DMA_Req}, 8'h00);
        chk("rx_pop_drop", {7'd0, RX_Data_Read}, 8'h00);
        chk("rx_mem", mem[a], d);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (DMA_Ready !== 1'b1 && n < 20) begin tick; n++; end
        chk(tag, {7'd0, DMA_Ready}, 8'h01);
    endtask

    initial begin
        // Reset state
        do_reset;
        chk_idle("rst");

        // Single RX byte, grant two cycles after request
        RX_Data = 8'hA5; RX_Empty = 1'b0;
        tick;
        chk("rx1_req", {7'd0, DMA_Req}, 8'h01);
        chk("rx1_cs0", {7'd0, RAM_Cs}, 8'h00);
        tick;
        chk("rx1_hold", {7'd0, DMA_Req}, 8'h01);
        DMA_Ack = 1'b1;
        tick;
        chk("rx1_pop",  {7'd0, RX_Data_Read}, 8'h01);
        chk("rx1_addr", RAM_Addr, 8'h00);
        chk("rx1_dbo",  Databus_o, 8'hA5);
        chk("rx1_oe",   {7'd0, Databus_oe}, 8'h01);
        RX_Empty = 1'b1; DMA_Ack = 1'b0;
        tick;
        chk("rx1_req0", {7'd0, DMA_Req}, 8'h00);
        chk("rx1_pop0", {7'd0, RX_Data_Read}, 8'h00);
        chk("rx1_mem",  mem[8'h00], 8'hA5);

        // Four bytes wrap at RX_LEN
        do_reset;
        rx_byte(8'h11, 8'h00);
        rx_byte(8'h22, 8'h01);
        rx_byte(8'h33, 8'h02);
        rx_byte(8'h44, 8'h00);

        // Two-byte TX, transmitter always ready
        do_reset;
        DMA_Ack = 1'b1; TX_Ready = 1'b1; DMA_Tx_Start = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        chk("tx_rd0_oen",  {7'd0, RAM_Oen}, 8'h01);
        chk("tx_rd0_addr", RAM_Addr, 8'h04);
        chk("tx_rd0_rdy",  {7'd0, DMA_Ready}, 8'h00);
        tick;
        chk("tx_lat_cs", {7'd0, RAM_Cs}, 8'h00);
        tick;
        chk("tx_b0_data", TX_Data, 8'h3C);
        chk("tx_b0_val",  {7'd0, TX_Valid}, 8'h01);
        tick;
        chk("tx_rd1_addr", RAM_Addr, 8'h05);
        chk("tx_rd1_val",  {7'd0, TX_Valid}, 8'h00);
        tick; tick;
        chk("tx_b1_data", TX_Data, 8'hC3);
        chk("tx_b1_rdy",  {7'd0, DMA_Ready}, 8'h00);
        tick;
        chk("tx_done_rdy", {7'd0, DMA_Ready}, 8'h01);
        chk("tx_done_val", {7'd0, TX_Valid}, 8'h00);

        // Transmitter stall for five cycles; a start during TX is ignored
        do_reset;
        DMA_Ack = 1'b1; DMA_Tx_Start = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        chk("st_rd_addr", RAM_Addr, 8'h04);
        tick; tick;
        chk("st_data0", TX_Data, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            DMA_Tx_Start = (i == 1);
            tick;
            chk("st_val",  {7'd0, TX_Valid}, 8'h01);
            chk("st_data", TX_Data, 8'h3C);
            chk("st_cs",   {7'd0, RAM_Cs}, 8'h00);
            chk("st_rdy",  {7'd0, DMA_Ready}, 8'h00);
        end
        DMA_Tx_Start = 1'b0; TX_Ready = 1'b1;
        tick;
        chk("st_rd1_addr", RAM_Addr, 8'h05);
        tick; tick;
        chk("st_data1", TX_Data, 8'hC3);
        tick;
        chk("st_done", {7'd0, DMA_Ready}, 8'h01);
        tick;
        chk("st_ignored_rdy", {7'd0, DMA_Ready}, 8'h01);
        chk("st_ignored_cs",  {7'd0, RAM_Cs}, 8'h00);

        // Start during the RX write cycle is deferred to IDLE
        do_reset;
        RX_Data = 8'h5A; RX_Empty = 1'b0; DMA_Ack = 1'b1;
        tick;
        chk("p_req", {7'd0, DMA_Req}, 8'h01);
        tick;
        chk("p_wen", {7'd0, RAM_Wen}, 8'h01);
        DMA_Tx_Start = 1'b1; RX_Empty = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        chk("p_idle_wen", {7'd0, RAM_Wen}, 8'h00);
        chk("p_idle_req", {7'd0, DMA_Req}, 8'h00);
        chk("p_mem", mem[8'h00], 8'h5A);
        tick;
        chk("p_tx_oen",  {7'd0, RAM_Oen}, 8'h01);
        chk("p_tx_addr", RAM_Addr, 8'h04);
        TX_Ready = 1'b1;
        wait_ready("p_drain");

        // Start and RX byte together in IDLE: TX first, RX afterwards
        RX_Data = 8'h77; RX_Empty = 1'b0; DMA_Tx_Start = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        chk("pri_oen", {7'd0, RAM_Oen}, 8'h01);
        chk("pri_req", {7'd0, DMA_Req}, 8'h00);
        tick; tick;
        chk("pri_data", TX_Data, 8'h3C);
        begin
            int n;
            n = 0;
            while (RX_Data_Read !== 1'b1 && n < 12) begin tick; n++; end
        end
        chk("pri_rx_pop",  {7'd0, RX_Data_Read}, 8'h01);
        chk("pri_rx_addr", RAM_Addr, 8'h01);
        chk("pri_rx_dbo",  Databus_o, 8'h77);
        chk("pri_tx_done", {7'd0, DMA_Ready}, 8'h01);
        RX_Empty = 1'b1;
        tick;

        // Reset in TX_SEND after the first byte, then TX restarts at TX_BASE
        do_reset;
        DMA_Ack = 1'b1; TX_Ready = 1'b1; DMA_Tx_Start = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        tick; tick; tick;
        chk("r_rd1_addr", RAM_Addr, 8'h05);
        TX_Ready = 1'b0;
        tick; tick;
        chk("r_send_val", {7'd0, TX_Valid}, 8'h01);
        Rst = 1'b1;
        tick;
        chk_idle("r_tx");
        Rst = 1'b0; DMA_Tx_Start = 1'b1;
        tick;
        DMA_Tx_Start = 1'b0;
        chk("r_restart_addr", RAM_Addr, 8'h04);
        chk("r_restart_oen",  {7'd0, RAM_Oen}, 8'h01);
        TX_Ready = 1'b1;
        wait_ready("r_drain");

        // Reset in RX_REQ
        DMA_Ack = 1'b0; RX_Data = 8'h99; RX_Empty = 1'b0;
        tick;
        chk("rr_req", {7'd0, DMA_Req}, 8'h01);
        Rst = 1'b1; RX_Empty = 1'b1;
        tick;
        chk_idle("r_rx");
        Rst = 1'b0;
        tick;
        chk("rr_after", {7'd0, DMA_Req}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
